// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller between the MEM-stage data port (D) and the IF-stage
// instruction port (I): fixed D priority with a starvation guard, one command in flight.
module sram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LINE_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req_rd,
    input  logic              d_req_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_done
);

    typedef enum logic [2:0] {IDLE, BUSY_D, BUSY_I, RESP_D, RESP_I} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_reg;
    logic [3:0] starve_reg;
    logic       d_pend;
    logic       grant_d;
    logic       grant_i;

    assign d_pend  = d_req_rd | d_req_wr;
    assign d_ready = ~d_pend | (state_reg == RESP_D);
    assign i_ready = ~i_req  | (state_reg == RESP_I);

    // The counter only increments while below LIMIT, so it saturates without wrapping.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_reg == IDLE) begin
            if (d_pend && i_req) begin
                if (starve_reg < LIMIT) grant_d = 1'b1;
                else                    grant_i = 1'b1;
            end else if (d_pend) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            starve_reg <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            d_rdata    <= '0;
            i_rdata    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_d) begin
                        mem_addr   <= d_addr;
                        mem_wdata  <= d_wdata;
                        mem_write  <= d_req_wr;
                        mem_read   <= ~d_req_wr;
                        starve_reg <= i_req ? starve_reg + 4'd1 : 4'd0;
                        state_reg  <= BUSY_D;
                    end else if (grant_i) begin
                        mem_addr   <= i_addr;
                        mem_read   <= 1'b1;
                        mem_write  <= 1'b0;
                        starve_reg <= 4'd0;
                        state_reg  <= BUSY_I;
                    end
                end
                BUSY_D: begin
                    if (mem_done) begin
                        if (mem_read) d_rdata <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state_reg <= RESP_D;
                    end
                end
                BUSY_I: begin
                    if (mem_done) begin
                        i_rdata   <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state_reg <= RESP_I;
                    end
                end
                RESP_D, RESP_I: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
